// File: rtl/sb_1237_uart_pkg.sv
// Shared constants and state encodings for the status-message UART transmitter.
package sb_1237_uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
  localparam int DEF_MAX_LEN      = 16;

  typedef enum logic [1:0] {
    MSG_IDLE,
    MSG_SEND,
    MSG_DONE
  } msg_state_e;

  typedef enum logic [2:0] {
    BYTE_IDLE,
    BYTE_START,
    BYTE_DATA,
    BYTE_STOP,
    BYTE_GAP
  } byte_state_e;

endpackage

// File: rtl/sb_1237_uart_byte_tx.sv
// 8N1 byte serializer with a one-clock idle GAP after each stop bit.
// A load seen during GAP chains straight into the next start bit.
module sb_1237_uart_byte_tx
  import sb_1237_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done,
  output logic       stop_last
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  byte_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      BYTE_IDLE: begin
        tx_d = 1'b1;
        if (load) begin
          state_d = BYTE_START;
          baud_d  = '0;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      BYTE_START: begin
        if (baud_end) begin
          state_d = BYTE_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      BYTE_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = BYTE_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      BYTE_STOP: begin
        if (baud_end) begin
          state_d = BYTE_GAP;
          baud_d  = '0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      BYTE_GAP: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (load) begin
          state_d = BYTE_START;
          shift_d = data;
          tx_d    = 1'b0;
        end else begin
          state_d = BYTE_IDLE;
        end
      end
      default: begin
        state_d = BYTE_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BYTE_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // stop_last warns the owner one clock early so its done lands on the GAP cycle.
  assign tx        = tx_q;
  assign byte_done = (state_q == BYTE_GAP);
  assign stop_last = (state_q == BYTE_STOP) && baud_end;

endmodule

// File: rtl/sb_1237_msg_uart_tx.sv
// Message-level transmitter: latches a right-aligned string and length, then
// feeds its characters first-to-last into the byte serializer.
module sb_1237_msg_uart_tx
  import sb_1237_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MAX_LEN      = DEF_MAX_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 transmit,
  input  logic [8*MAX_LEN-1:0] str,
  input  logic [7:0]           str_len,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  msg_state_e           state_q, state_d;
  logic [8*MAX_LEN-1:0] msg_q, msg_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     k_q, k_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LEN_W-1:0]     len_clamped;
  logic [LEN_W-1:0]     acc_idx;
  logic [LEN_W-1:0]     send_idx;
  logic                 load;
  logic [7:0]           byte_data;
  logic                 byte_done;
  logic                 stop_last;

  assign len_clamped = (str_len > 8'(MAX_LEN)) ? LEN_MAX : LEN_W'(str_len);
  // Character k sits at byte lane len-1-k; during GAP we fetch lane for k+1.
  assign acc_idx  = len_clamped - LEN_W'(1);
  assign send_idx = len_q - k_q - LEN_W'(2);

  always_comb begin
    state_d   = state_q;
    msg_d     = msg_q;
    len_d     = len_q;
    k_d       = k_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    byte_data = str[8*acc_idx +: 8];
    case (state_q)
      MSG_SEND: begin
        byte_data = msg_q[8*send_idx +: 8];
        if (stop_last && (k_q == len_q - LEN_W'(1))) begin
          state_d = MSG_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (byte_done) begin
          k_d  = k_q + LEN_W'(1);
          load = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        state_d = MSG_IDLE;
        if (transmit) begin
          msg_d = str;
          len_d = len_clamped;
          k_d   = '0;
          if (len_clamped == '0) begin
            state_d = MSG_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = MSG_SEND;
            busy_d  = 1'b1;
            load    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MSG_IDLE;
      msg_q   <= '0;
      len_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      len_q   <= len_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sb_1237_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .data     (byte_data),
    .tx       (tx),
    .byte_done(byte_done),
    .stop_last(stop_last)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_sb_1237_msg_uart_tx.sv
// Scoreboard bench: stimulus queues expected frames/done cycles, a negedge monitor decodes tx.
module tb_sb_1237_msg_uart_tx;

  localparam int CPB = 4;
  localparam int F   = 10 * CPB + 1;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         transmit = 1'b0;
  logic [127:0] str = '0;
  logic [7:0]   str_len = '0;
  logic         tx, busy, done;

  int     cyc = 0;
  logic   rst_d1 = 1'b1;
  bit     mon_en = 1'b0;
  bit     final_req = 1'b0;
  int     busy_lo = 1, busy_hi = 0;
  frame_t exp_frames[$];
  int     exp_done[$];
  int     checks = 0, failures = 0;

  sb_1237_msg_uart_tx #(.CLKS_PER_BIT(CPB), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .transmit(transmit), .str(str), .str_len(str_len),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_d1 <= rst;
  end

  // ---------------- monitor / scoreboard ----------------
  bit         mon_active = 1'b0;
  int         mon_start = 0;
  logic       level[10];
  bit         unstable = 1'b0;
  bit         have_exp = 1'b0;
  logic [7:0] cur_exp = '0;
  bit         final_done = 1'b0;

  always @(negedge clk) begin
    frame_t     fr;
    int         dexp;
    int         off;
    bit         exp_busy;
    logic [9:0] got, want;
    if (mon_en) begin
      if (rst_d1) begin
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL reset_state cyc=%0d got tx=%b busy=%b done=%b exp tx=1 busy=0 done=0", cyc, tx, busy, done);
        end
      end
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checks++;
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d got done=1 exp done=0", cyc);
        end else begin
          dexp = exp_done.pop_front();
          if (dexp != cyc) begin
            failures++;
            $display("FAIL done_cycle got=%0d exp=%0d", cyc, dexp);
          end
        end
      end else if (exp_done.size() > 0 && exp_done[0] < cyc) begin
        checks++;
        failures++;
        dexp = exp_done.pop_front();
        $display("FAIL missing_done cyc=%0d got done=0 exp done at %0d", cyc, dexp);
      end
      if (rst) begin
        mon_active = 1'b0;
      end else if (mon_active) begin
        off = cyc - mon_start;
        if (off < 40) begin
          if (off % CPB == 0) level[off/CPB] = tx;
          else if (tx !== level[off/CPB]) unstable = 1'b1;
        end else begin
          for (int i = 0; i < 10; i++) got[i] = level[i];
          if (have_exp) begin
            want = {1'b1, cur_exp, 1'b0};
            checks++;
            if (got !== want) begin
              failures++;
              $display("FAIL frame_bits start=%0d got=%03h exp=%03h", mon_start, got, want);
            end
          end
          checks++;
          if (unstable) begin
            failures++;
            $display("FAIL bit_hold start=%0d got unstable bit level exp constant for %0d cycles", mon_start, CPB);
          end
          checks++;
          if (tx !== 1'b1) begin
            failures++;
            $display("FAIL gap_level cyc=%0d got=%b exp=1", cyc, tx);
          end
          mon_active = 1'b0;
        end
      end else if (tx !== 1'b1) begin
        checks++;
        if (exp_frames.size() == 0) begin
          failures++;
          have_exp = 1'b0;
          $display("FAIL unexpected_frame cyc=%0d got tx=%b exp idle 1", cyc, tx);
        end else begin
          fr = exp_frames.pop_front();
          have_exp = 1'b1;
          cur_exp = fr.b;
          if (fr.start != cyc) begin
            failures++;
            $display("FAIL start_cycle byte=%02h got=%0d exp=%0d", fr.b, cyc, fr.start);
          end
        end
        mon_active = 1'b1;
        mon_start = cyc;
        level[0] = tx;
        unstable = 1'b0;
      end else if (exp_frames.size() > 0 && exp_frames[0].start < cyc) begin
        checks++;
        failures++;
        fr = exp_frames.pop_front();
        $display("FAIL missing_frame cyc=%0d got no start bit exp byte %02h at %0d", cyc, fr.b, fr.start);
      end
      if (final_req && !final_done) begin
        final_done = 1'b1;
        checks += 2;
        if (exp_frames.size() != 0) begin
          failures++;
          $display("FAIL leftover_frames got=%0d exp=0", exp_frames.size());
        end
        if (exp_done.size() != 0) begin
          failures++;
          $display("FAIL leftover_done got=%0d exp=0", exp_done.size());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after an edge; transmit is sampled on the next edge (E0).
  task automatic send_msg(input logic [127:0] s, input logic [7:0] l,
                          input logic [127:0] eb, input int n, output int base);
    frame_t fr;
    base = cyc;
    transmit = 1'b1;
    str = s;
    str_len = l;
    for (int k = 0; k < n; k++) begin
      fr.b = eb[8*(n-1-k) +: 8];
      fr.start = base + 1 + k*F;
      exp_frames.push_back(fr);
    end
    busy_lo = base + 1;
    if (n == 0) begin
      busy_hi = base;
      exp_done.push_back(base + 1);
    end else begin
      busy_hi = base + n*F - 1;
      exp_done.push_back(base + n*F);
    end
    $display("TX msg at cyc=%0d str_len=%0d expected_frames=%0d", base, l, n);
    @(posedge clk);
    #1;
    transmit = 1'b0;
    str = '1;
    str_len = 8'hFF;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    send_msg("GBI1-W-#", 8'd8, 128'h47424931_2D572D23, 8, base);
    wait_until(base + 8*F + 3);

    send_msg("XYZ", 8'd0, 128'h0, 0, base);
    wait_until(base + 5);

    send_msg("0123456789ABCDEF", 8'd20, 128'h30313233_34353637_38394142_43444546, 16, base);
    wait_until(base + 16*F + 3);

    send_msg("GB3-", 8'd4, 128'h4742332D, 4, base);
    wait_until(base + 50);
    $display("TX ignored request at cyc=%0d", cyc);
    transmit = 1'b1;
    str = "ZZZZ";
    str_len = 8'd4;
    @(posedge clk);
    #1;
    transmit = 1'b0;
    wait_until(base + 4*F);
    send_msg("PICK", 8'd4, 128'h5049434B, 4, base);
    wait_until(base + 4*F + 3);

    send_msg("GBI2-P-#", 8'd8, 128'h47424932_2D502D23, 8, base);
    wait_until(base + 60);
    $display("RST asserted at cyc=%0d", cyc);
    rst = 1'b1;
    exp_frames.delete();
    exp_done.delete();
    busy_hi = base + 60;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_msg("GB7-PICK-3", 8'd10, 128'h4742_372D_5049_434B_2D33, 10, base);
    wait_until(base + 10*F + 3);

    send_msg(128'hA5, 8'd1, 128'hA5, 1, base);
    wait_until(base + F + 5);

    final_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_1237_msg_uart_tx.md
# sb_1237_msg_uart_tx

Byte-serial UART transmitter for the status messages ("GBI…", "GB…-PICK-#") built by the bot's top-level controller. Latches a right-aligned, packed ASCII string of up to 16 characters plus a length on a single-cycle `transmit` pulse, then sends the characters first-to-last as 8N1 frames on `tx`. Pulses `done` when the last frame is complete. Sits directly downstream of the top controller and drives the board's serial/Xbee TX pin.

## Interface
- `CLKS_PER_BIT`, default 434: clocks per bit (50 MHz / 115200 baud).
- `MAX_LEN`, default 16: maximum characters per message; `str` width = 8*MAX_LEN.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset. Synchronous, active-high, single clock domain.
- `transmit`  in  1  start request, one-cycle pulse.
- `str`  in  128  packed string. Character k (0-based, first sent) = `str[8*(len-k)-1 -: 8]`.
- `str_len`  in  8  character count.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  message in progress.
- `done`  out  1  one-cycle pulse after the last stop bit.

## Operation
- Top FSM states:
  - IDLE: on `transmit`=1, latch `str` and len = min(`str_len`, MAX_LEN) into internal registers; k=0; go to SEND. If len=0, go to DONE instead.
  - SEND: present byte k to the byte serializer; on its completion, k++. If k==len go to DONE, else stay in SEND.
  - DONE: `done`=1 for one cycle; return to IDLE.
- Byte serializer states, each lasting CLKS_PER_BIT cycles except GAP:
  - START: `tx`=0.
  - DATA: 8 bits, LSB first.
  - STOP: `tx`=1.
  - GAP: exactly 1 clock, `tx`=1.
- `transmit` while `busy`=1 is ignored; the latched string is not modified.
- `str` and `str_len` are sampled only in the accept cycle and may change afterwards.
- `str_len` > MAX_LEN is clamped to MAX_LEN.
- Bit counter: 3 bits. Baud counter: ceil(log2(CLKS_PER_BIT)) bits, counts 0..CLKS_PER_BIT-1 and wraps.
- Reset has priority over everything, including mid-frame:
  - next cycle `tx`=1, `busy`=0, `done`=0, FSMs return to IDLE, counters are cleared;
  - the aborted message produces no `done`.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0.
- Let E0 be the edge that samples `transmit`=1 in IDLE, and F = 10*CLKS_PER_BIT + 1.
- Byte k:
  - start bit drives `tx` in cycles 1+k*F .. k*F+CLKS_PER_BIT after E0;
  - data bit b follows at +(b+1)*CLKS_PER_BIT;
  - stop bit, then the GAP cycle at k*F+10*CLKS_PER_BIT+1.
- `busy`=1 from cycle 1 through cycle len*F-1.
- `done`=1 in cycle len*F with `busy`=0.
- len=0: `done` in cycle 1 with no `tx` activity and `busy` never high.
- A `transmit` in the `done` cycle or any later cycle is accepted; the next start bit follows one cycle later.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `sb_1237_uart_pkg`:
  - CLKS_PER_BIT default;
  - MAX_LEN;
  - top-FSM state encoding (IDLE/SEND/DONE);
  - byte-FSM state encoding (IDLE/START/DATA/STOP/GAP).
- One sub-module, `sb_1237_uart_byte_tx`:
  - inputs: `clk`, `rst`, `load`, `data[7:0]`;
  - outputs: `tx`, `byte_done` (one-cycle pulse at end of GAP).
- The top instance owns the message register, the length clamp, the index counter and `busy`/`done`.

## Test plan
All scenarios use CLKS_PER_BIT=4, so F=41.
- `str`="GBI1-W-#", `str_len`=8, `transmit` pulse:
  - `tx` decodes to 0x47,0x42,0x49,0x31,0x2D,0x57,0x2D,0x23 in order;
  - first start bit at cycle 1;
  - `done` at cycle 328; `busy` high cycles 1–327.
- `str_len`=0 → `done` at cycle 1, `tx` constant 1, `busy` never asserted.
- `str_len`=20 with a 16-char string → exactly 16 frames, `done` at cycle 656.
- Second `transmit` with a different `str` at cycle 50 of a 4-byte message:
  - ignored; original 4 bytes sent; one `done` at 164.
  - A new `transmit` at cycle 164 starts its start bit at cycle 165.
- `rst` asserted at cycle 60 of an 8-byte message:
  - cycle 61 `tx`=1, `busy`=0; no `done` ever.
  - A subsequent `transmit` sends its full message correctly.
- Bit-level check: byte 0xA5 → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, then 1 GAP cycle high.
